// File: rtl/t5_pkg.sv
// rtl/t5_pkg.sv - shared CLINT register offsets, hart-id width, ack states and byte-lane merge helper
package t5_pkg;

    localparam logic [15:0] T5_CLINT_MSIP     = 16'h0000;
    localparam logic [15:0] T5_CLINT_MTIMECMP = 16'h4000;
    localparam logic [15:0] T5_CLINT_MTIME    = 16'hBFF8;
    localparam int          T5_HART_W         = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } t5_ack_state_e;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/t5_clint_cmp.sv
// rtl/t5_clint_cmp.sv - one hart's mtimecmp register pair and registered timer-interrupt compare
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   we_lo_i, we_hi_i    write strobe for the low / high mtimecmp word
//   wdata_i, sel_i      write data and byte lane enables
//   mtime_i             current mtime value
//   mtimecmp_o          current mtimecmp value (for read-back)
//   mtip_o              registered (mtime >= mtimecmp)
module t5_clint_cmp
    import t5_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  sel_i,
    input  logic [63:0] mtime_i,
    output logic [63:0] mtimecmp_o,
    output logic        mtip_o
);

    logic [63:0] cmp_q, cmp_d;
    logic        mtip_q;

    always_comb begin
        cmp_d = cmp_q;
        if (we_lo_i) cmp_d[31:0]  = byte_merge(cmp_q[31:0],  wdata_i, sel_i);
        if (we_hi_i) cmp_d[63:32] = byte_merge(cmp_q[63:32], wdata_i, sel_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtip_q <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            // Compares the pre-edge values, so mtip trails a change by one cycle.
            mtip_q <= (mtime_i >= cmp_q);
        end
    end

    assign mtimecmp_o = cmp_q;
    assign mtip_o     = mtip_q;

endmodule

// File: rtl/t5_clint.sv
// rtl/t5_clint.sv - core-local interruptor: mtime, per-hart mtimecmp/msip, bus responder (optional T5_CLINT_PRESCALE_EN)
//
// Ports:
//   sys_clk, sys_rst    clock, asynchronous active-high reset
//   wbs_adr             word address [31:2]; only [15:2] decoded
//   wbs_dti, wbs_sel    write data and byte lane enables
//   wbs_wre, wbs_stb    write/read select and transfer request
//   wbs_dto, wbs_ack    registered read data and one-cycle acknowledge
//   mtip, msip          per-hart timer and software interrupt lines
// Macro T5_CLINT_PRESCALE_EN: mtime advances once every DIV cycles.
module t5_clint
    import t5_pkg::*;
#(
    parameter int NHART = 4,
    parameter int DIV   = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [29:0]      wbs_adr,
    input  logic [31:0]      wbs_dti,
    input  logic [3:0]       wbs_sel,
    input  logic             wbs_wre,
    input  logic             wbs_stb,
    output logic [31:0]      wbs_dto,
    output logic             wbs_ack,
    output logic [NHART-1:0] mtip,
    output logic [NHART-1:0] msip
);

    t5_ack_state_e state_q;
    logic          ack_q;
    logic [31:0]   dto_q;
    logic [63:0]   mtime_q, mtime_d;
    logic [NHART-1:0] msip_q;
    logic [63:0]   cmp_val [NHART];
    logic [31:0]   rdata;
    logic          tick;

    // Upper address bits are outside the decoded window.
    logic unused_adr;
    assign unused_adr = ^wbs_adr[29:14];

    logic [15:0]          off;
    logic                 req, wr, hi;
    logic                 sel_msip, sel_cmp, sel_mtime, mtime_wr;
    logic [T5_HART_W-1:0] hart_msip, hart_cmp;

    assign off       = {wbs_adr[13:0], 2'b00};
    assign req       = wbs_stb && (state_q == ST_IDLE);
    assign wr        = req && wbs_wre;
    assign hi        = off[2];
    assign sel_msip  = (off[15:4] == T5_CLINT_MSIP[15:4]);
    assign sel_cmp   = (off[15:5] == T5_CLINT_MTIMECMP[15:5]);
    assign sel_mtime = (off[15:3] == T5_CLINT_MTIME[15:3]);
    assign hart_msip = off[3:2];
    assign hart_cmp  = off[4:3];
    assign mtime_wr  = wr && sel_mtime;

`ifdef T5_CLINT_PRESCALE_EN
    logic [31:0] presc_q;

    assign tick = (presc_q == 32'(DIV - 1));

    // A write to mtime restarts the divide period so the next step is a full DIV away.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            presc_q <= 32'd0;
        end else if (mtime_wr || tick) begin
            presc_q <= 32'd0;
        end else begin
            presc_q <= presc_q + 32'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // A bus write replaces the increment for that cycle; unwritten bytes keep the old value.
    always_comb begin
        mtime_d = mtime_q + {63'd0, tick};
        if (mtime_wr) begin
            if (hi) mtime_d = {byte_merge(mtime_q[63:32], wbs_dti, wbs_sel), mtime_q[31:0]};
            else    mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], wbs_dti, wbs_sel)};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mtime_q <= 64'd0;
        end else begin
            mtime_q <= mtime_d;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            msip_q <= '0;
        end else begin
            for (int h = 0; h < NHART; h++) begin
                if (wr && sel_msip && hart_msip == T5_HART_W'(h) && wbs_sel[0]) begin
                    msip_q[h] <= wbs_dti[0];
                end
            end
        end
    end

    for (genvar g = 0; g < NHART; g++) begin : g_cmp
        t5_clint_cmp u_cmp (
            .clk_i      (sys_clk),
            .rst_i      (sys_rst),
            .we_lo_i    (wr && sel_cmp && hart_cmp == T5_HART_W'(g) && !hi),
            .we_hi_i    (wr && sel_cmp && hart_cmp == T5_HART_W'(g) && hi),
            .wdata_i    (wbs_dti),
            .sel_i      (wbs_sel),
            .mtime_i    (mtime_q),
            .mtimecmp_o (cmp_val[g]),
            .mtip_o     (mtip[g])
        );
    end

    // Harts at or above NHART never match and therefore read as zero.
    always_comb begin
        rdata = 32'd0;
        for (int h = 0; h < NHART; h++) begin
            if (sel_msip && hart_msip == T5_HART_W'(h)) rdata = {31'd0, msip_q[h]};
            if (sel_cmp && hart_cmp == T5_HART_W'(h))   rdata = hi ? cmp_val[h][63:32] : cmp_val[h][31:0];
        end
        if (sel_mtime) rdata = hi ? mtime_q[63:32] : mtime_q[31:0];
    end

    // Ack state machine; a request is taken only from IDLE, giving one idle cycle between acks.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dto_q   <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wbs_stb) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        dto_q   <= wbs_wre ? 32'd0 : rdata;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    dto_q   <= 32'd0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    dto_q   <= 32'd0;
                end
            endcase
        end
    end

    assign wbs_ack = ack_q;
    assign wbs_dto = dto_q;
    assign msip    = msip_q;

endmodule

// File: tb/tb_t5_clint.sv
// tb/tb_t5_clint.sv - self-checking bench for t5_clint against a time-based register model
module tb_t5_clint;

`ifdef T5_CLINT_PRESCALE_EN
    localparam int TB_DIV = 4;
`else
    localparam int TB_DIV = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] adr = '0;
    logic [31:0] dti = '0;
    logic [3:0]  sel = '0;
    logic        wre = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] dto;
    logic        ack;
    logic [3:0]  mtip;
    logic [3:0]  msip;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;

    longint unsigned mt_base;
    int              mt_cyc;
    longint unsigned cmp_m [4];
    logic [3:0]      msip_m;

    t5_clint #(.NHART(4), .DIV(TB_DIV)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .wbs_adr (adr),
        .wbs_dti (dti),
        .wbs_sel (sel),
        .wbs_wre (wre),
        .wbs_stb (stb),
        .wbs_dto (dto),
        .wbs_ack (ack),
        .mtip    (mtip),
        .msip    (msip)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; mtime is a function of this count.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mt_base = 0;
        mt_cyc  = 0;
        for (int h = 0; h < 4; h++) cmp_m[h] = 64'hFFFF_FFFF_FFFF_FFFF;
        msip_m = 4'b0000;
    endtask

    // mtime value held after edge number c.
    function automatic longint unsigned mt_at(input int c);
        return mt_base + longint'(c - mt_cyc) / TB_DIV;
    endfunction

    function automatic logic [31:0] lane_mix(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] model_rd(input logic [15:0] off, input int c);
        longint unsigned v;
        if (off < 16'h0010) return {31'd0, msip_m[off[3:2]]};
        if (off >= 16'h4000 && off < 16'h4020) begin
            v = cmp_m[off[4:3]];
            return off[2] ? v[63:32] : v[31:0];
        end
        if (off == 16'hBFF8 || off == 16'hBFFC) begin
            v = mt_at(c);
            return off[2] ? v[63:32] : v[31:0];
        end
        return 32'd0;
    endfunction

    task automatic model_wr(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s, input int e);
        longint unsigned v;
        if (off < 16'h0010) begin
            if (s[0]) msip_m[off[3:2]] = d[0];
        end else if (off >= 16'h4000 && off < 16'h4020) begin
            v = cmp_m[off[4:3]];
            if (off[2]) v[63:32] = lane_mix(v[63:32], d, s);
            else        v[31:0]  = lane_mix(v[31:0], d, s);
            cmp_m[off[4:3]] = v;
        end else if (off == 16'hBFF8 || off == 16'hBFFC) begin
            v = mt_at(e - 1);
            if (off[2]) v[63:32] = lane_mix(v[63:32], d, s);
            else        v[31:0]  = lane_mix(v[31:0], d, s);
            mt_base = v;
            mt_cyc  = e;
        end
    endtask

    // Called at a negedge; one full transfer, returning at the negedge after ack falls.
    task automatic xfer(input logic [15:0] off, input logic w, input logic [31:0] d, input logic [3:0] s);
        int e;
        adr = {16'd0, off[15:2]};
        dti = d;
        sel = s;
        wre = w;
        stb = 1'b1;
        @(negedge clk);
        e = cyc;
        chk("ack_high", {63'd0, ack}, 64'd1);
        if (!w) chk($sformatf("rdata_%h", off), {32'd0, dto}, {32'd0, model_rd(off, e - 1)});
        else    model_wr(off, d, s, e);
        stb = 1'b0;
        wre = 1'b0;
        @(negedge clk);
        chk("ack_low", {63'd0, ack}, 64'd0);
        chk("dto_idle", {32'd0, dto}, 64'd0);
    endtask

    task automatic check_irq();
        logic [3:0] em;
        for (int h = 0; h < 4; h++) em[h] = (mt_at(cyc - 1) >= cmp_m[h]);
        chk("mtip", {60'd0, mtip}, {60'd0, em});
        chk("msip", {60'd0, msip}, {60'd0, msip_m});
    endtask

    initial begin
        logic [15:0] off;
        logic        w;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", {63'd0, ack}, 64'd0);
        chk("rst_dto", {32'd0, dto}, 64'd0);
        chk("rst_mtip", {60'd0, mtip}, 64'd0);
        chk("rst_msip", {60'd0, msip}, 64'd0);
        rst = 1'b0;

        // mtime counts from release; read both halves.
        xfer(16'hBFF8, 1'b0, 32'd0, 4'hF);
        xfer(16'hBFFC, 1'b0, 32'd0, 4'hF);
        check_irq();

        // Hart 0 compare at 0x20; watch mtip[0] rise with mtip[3:1] quiet.
        xfer(16'h4004, 1'b1, 32'd0, 4'hF);
        xfer(16'h4000, 1'b1, 32'h20, 4'hF);
        xfer(16'h4000, 1'b0, 32'd0, 4'hF);
        repeat (48) begin
            @(negedge clk);
            check_irq();
        end
        chk("mtip0_rose", {60'd0, mtip}, 64'd1);

        // Low-word wrap carries into the high word.
        xfer(16'hBFF8, 1'b1, 32'hFFFF_FFFE, 4'hF);
        xfer(16'hBFFC, 1'b1, 32'd0, 4'hF);
        xfer(16'hBFFC, 1'b0, 32'd0, 4'hF);
        xfer(16'hBFF8, 1'b0, 32'd0, 4'hF);
        check_irq();

        // msip lane enable.
        xfer(16'h0008, 1'b1, 32'h1, 4'b0001);
        chk("msip_set", {60'd0, msip}, 64'h4);
        xfer(16'h0008, 1'b1, 32'h0, 4'b0000);
        chk("msip_nosel", {60'd0, msip}, 64'h4);
        check_irq();

        // stb held across three transfers to an unmapped word.
        adr = {16'd0, 14'h0400};
        wre = 1'b0;
        stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("b2b_ack_%0d", i), {63'd0, ack}, {63'd0, (i % 2) == 1});
            if (ack) chk("b2b_dto", {32'd0, dto}, 64'd0);
            if (i == 5) stb = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end", {63'd0, ack}, 64'd0);

        // Randomized transfers against the model.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0:       off = {12'd0, 2'($urandom_range(0, 3)), 2'b00};
                1:       off = 16'h4000 + 16'($urandom_range(0, 7) * 4);
                2:       off = ($urandom_range(0, 1) == 1) ? 16'hBFFC : 16'hBFF8;
                3:       off = 16'h2000 | (16'($urandom) & 16'h0FFC);
                default: off = 16'hBFF8;
            endcase
            w = ($urandom_range(0, 2) == 0);
            xfer(off, w, $urandom, 4'($urandom));
            check_irq();
        end

        // Reset arriving on the cycle a write is acked.
        adr = {16'd0, 14'h0001};
        dti = 32'h1;
        sel = 4'hF;
        wre = 1'b1;
        stb = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ack_before", {63'd0, ack}, 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_ack", {63'd0, ack}, 64'd0);
        chk("midrst_msip", {60'd0, msip}, 64'd0);
        chk("midrst_mtip", {60'd0, mtip}, 64'd0);
        @(negedge clk);
        stb = 1'b0;
        wre = 1'b0;
        model_reset();
        rst = 1'b0;
        xfer(16'h0004, 1'b0, 32'd0, 4'hF);
        xfer(16'h4000, 1'b0, 32'd0, 4'hF);
        xfer(16'hBFF8, 1'b0, 32'd0, 4'hF);
        check_irq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
